pixel_out_buffer: RTL and testbench
===================================

Name: pixel_out_buffer

Overview:
Downstream end of the filter output path. Accepts the selected 3-channel pixel stream (strobe-only, no backpressure) from the output mux and buffers it in a small FIFO. Re-emits pixels on a valid/ready interface to the frame writer, tagged with start-of-frame, end-of-line and end-of-frame markers. Reports drop/overflow status.

Parameters:
COLOR_CHANNEL, 8, bits per colour channel
FIFO_DEPTH, 16, buffer entries; power of two, >= 4
IMG_WIDTH, 640, pixels per line
IMG_HEIGHT, 480, lines per frame

Ports:
i_clk  input  1  system clock; all logic on rising edge
i_reset  input  1  asynchronous, active-high reset
i_data  input  [2:0][COLOR_CHANNEL-1:0]  pixel from output mux; [2]=R, [1]=G, [0]=B
i_data_ready  input  1  one-cycle strobe; i_data valid this cycle
o_pixel  output  [2:0][COLOR_CHANNEL-1:0]  head-of-FIFO pixel
o_valid  output  1  o_pixel valid
i_ready  input  1  downstream accepts; transfer = o_valid & i_ready
o_sof  output  1  o_pixel is col 0, row 0 (qualified by o_valid)
o_eol  output  1  o_pixel is col IMG_WIDTH-1
o_eof  output  1  o_pixel is last pixel of frame
o_level  output  $clog2(FIFO_DEPTH)+1  current occupancy
o_overflow  output  1  sticky: a pixel was dropped

Behaviour:
- Reset (async assert, sync release): FIFO empty, pointers 0, o_valid=0, o_pixel=0, o_sof/o_eol/o_eof=0, o_level=0, o_overflow=0, col=row=0, FSM=IDLE.
- Write: i_data_ready=1 and (not full, or full with a pop this same cycle) -> entry stored at wr_ptr, wr_ptr++.
- Full with i_data_ready=1 and no pop: pixel dropped, o_overflow set; clears only on reset. Dropped pixels do not advance col/row.
- Read: first-word-fall-through; a pixel written in cycle N is on o_pixel with o_valid=1 from cycle N+1 (empty FIFO). o_pixel/o_valid stable while o_valid & !i_ready.
- Pop on o_valid & i_ready; next entry presented the following cycle with no bubble if occupancy > 1.
- Simultaneous push and pop: occupancy unchanged; legal at empty (pushed pixel shows next cycle) and at full.
- Pointers wrap mod FIFO_DEPTH; full/empty distinguished by an extra pointer MSB.
- o_level = wr_ptr - rd_ptr, updated the cycle after the event.
- Output-side counters (advance on transfer only): col 0..IMG_WIDTH-1, wraps to 0 with row++; row 0..IMG_HEIGHT-1, wraps to 0 after last line.
- o_sof = (col==0 && row==0); o_eol = (col==IMG_WIDTH-1); o_eof = o_eol && (row==IMG_HEIGHT-1). Combinational from counters; meaningful only with o_valid=1.
- FSM: IDLE (no pixel delivered this frame) -> ACTIVE on first transfer; ACTIVE -> IDLE on transfer with o_eof=1. Counters reset to 0 on that transfer. FSM state is visible only through the marker outputs.
- Reset mid-frame: all contents discarded, counters and FSM to 0/IDLE immediately.

Optional Feature:
PIXEL_OUT_GRAY_EN. When defined, each pixel is converted on write to Y = (R + 2G + B) >> 2. Sum is COLOR_CHANNEL+2 bits wide and truncated after the shift. Y is replicated to all three channels of o_pixel. FIFO stores only COLOR_CHANNEL bits per entry. When not defined, pixels pass through unchanged and the FIFO stores 3*COLOR_CHANNEL bits.

Test Plan:
- Reset, then single strobe i_data={8'h10,8'h20,8'h30} with i_ready=1 -> o_valid=1 next cycle, o_pixel matches, o_sof=1; o_valid=0 the cycle after.
- 16 strobes with i_ready=0 -> o_level=16, o_overflow=0; 17th strobe -> o_overflow=1, o_level stays 16. Then drain -> first 16 pixels out in order, 17th absent.
- At full, strobe with i_ready=1 in the same cycle -> no overflow, o_level stays 16, new pixel delivered last.
- IMG_WIDTH=4, IMG_HEIGHT=2, 8 pixels streamed -> o_eol on pixels 3 and 7; o_eof on pixel 7 only; o_sof on pixels 0 and 8 (next frame).
- Random i_ready stalls -> o_pixel held stable while stalled; output sequence equals input sequence.
- Assert i_reset mid-frame with 5 entries buffered -> o_valid=0, o_level=0 immediately; next pixel flagged o_sof=1.
- With PIXEL_OUT_GRAY_EN, input {8'hFF,8'h80,8'h00} -> o_pixel = {8'h7F,8'h7F,8'h7F}.

Source files
------------

// File: rtl/pixel_out_buffer.sv
// pixel_out_buffer: FWFT pixel FIFO with valid/ready output, frame markers and sticky overflow.
// Optional PIXEL_OUT_GRAY_EN converts each pixel to luma on write and stores one channel per entry.
module pixel_out_buffer #(
    parameter int COLOR_CHANNEL = 8,
    parameter int FIFO_DEPTH    = 16,
    parameter int IMG_WIDTH     = 640,
    parameter int IMG_HEIGHT    = 480
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset,
    input  logic [2:0][COLOR_CHANNEL-1:0]        i_data,
    input  logic                                 i_data_ready,
    output logic [2:0][COLOR_CHANNEL-1:0]        o_pixel,
    output logic                                 o_valid,
    input  logic                                 i_ready,
    output logic                                 o_sof,
    output logic                                 o_eol,
    output logic                                 o_eof,
    output logic [$clog2(FIFO_DEPTH):0]          o_level,
    output logic                                 o_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(IMG_WIDTH + 1);
    localparam int RW = $clog2(IMG_HEIGHT + 1);
`ifdef PIXEL_OUT_GRAY_EN
    localparam int EW = COLOR_CHANNEL;
`else
    localparam int EW = 3 * COLOR_CHANNEL;
`endif

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [EW-1:0] wr_entry, head;
    logic          empty, full, push, pop;
    logic [CW-1:0] col, col_n;
    logic [RW-1:0] row, row_n;
    state_t        state, state_n;

    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign o_valid = !empty;
    assign pop     = o_valid && i_ready;
    assign push    = i_data_ready && (!full || pop);
    assign o_level = wr_ptr - rd_ptr;
    assign head    = mem[rd_ptr[AW-1:0]];

`ifdef PIXEL_OUT_GRAY_EN
    logic [COLOR_CHANNEL+1:0] luma_sum;
    always_comb begin
        luma_sum = {2'b00, i_data[2]} + {1'b0, i_data[1], 1'b0} + {2'b00, i_data[0]};
        wr_entry = luma_sum[COLOR_CHANNEL+1:2];
    end
    assign o_pixel = empty ? '0 : {head, head, head};
`else
    assign wr_entry = i_data;
    assign o_pixel  = empty ? '0 : head;
`endif

    // Storage is not reset; occupancy is defined solely by the pointers.
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_entry;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_overflow <= 1'b0;
            col        <= '0;
            row        <= '0;
            state      <= IDLE;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (i_data_ready && full && !pop) o_overflow <= 1'b1;
            col   <= col_n;
            row   <= row_n;
            state <= state_n;
        end
    end

    assign o_sof = o_valid && (col == '0) && (row == '0);
    assign o_eol = o_valid && (col == CW'(IMG_WIDTH - 1));
    assign o_eof = o_eol && (row == RW'(IMG_HEIGHT - 1));

    // Position counters advance only on accepted transfers; end of frame returns to IDLE.
    always_comb begin
        state_n = state;
        col_n   = col;
        row_n   = row;
        if (pop) begin
            if (o_eof) begin
                state_n = IDLE;
                col_n   = '0;
                row_n   = '0;
            end else begin
                state_n = ACTIVE;
                col_n   = o_eol ? '0 : col + 1'b1;
                row_n   = o_eol ? row + 1'b1 : row;
            end
        end
    end
endmodule

// File: tb/tb_pixel_out_buffer.sv
// tb_pixel_out_buffer: table vectors plus scoreboard checks for pixel_out_buffer (W=4, H=2, depth 16).
module tb_pixel_out_buffer;
    localparam int W = 4;
    localparam int H = 2;
    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              i_reset;
    logic [2:0][7:0]   i_data;
    logic              i_data_ready;
    logic [2:0][7:0]   o_pixel;
    logic              o_valid;
    logic              i_ready;
    logic              o_sof, o_eol, o_eof;
    logic [4:0]        o_level;
    logic              o_overflow;

    pixel_out_buffer #(.COLOR_CHANNEL(8), .FIFO_DEPTH(DEPTH), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_data(i_data), .i_data_ready(i_data_ready),
        .o_pixel(o_pixel), .o_valid(o_valid), .i_ready(i_ready), .o_sof(o_sof),
        .o_eol(o_eol), .o_eof(o_eof), .o_level(o_level), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [23:0] q[$];
    int m_col = 0, m_row = 0;
    logic m_ovf = 1'b0;
    logic stall_prev = 1'b0;
    logic [23:0] prev_pix = '0;
    logic obs_valid, obs_sof;
    logic [4:0] obs_level;
    logic [23:0] obs_pix;
    int n_sof = 0, n_eol = 0, n_eof = 0;

    typedef struct {
        logic        s;
        logic [23:0] d;
        logic        r;
        logic        ev;
        logic [4:0]  el;
        logic        es;
    } vec_t;
    vec_t tbl[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] conv(input logic [23:0] d);
`ifdef PIXEL_OUT_GRAY_EN
        logic [9:0] s;
        s = {2'b00, d[23:16]} + {1'b0, d[15:8], 1'b0} + {2'b00, d[7:0]};
        return {s[9:2], s[9:2], s[9:2]};
`else
        return d;
`endif
    endfunction

    // One cycle: drive at the falling edge, observe, update the model, wait for the next falling edge.
    task automatic tick(input logic s, input logic [23:0] d, input logic r);
        logic xfer;
        logic [23:0] exp;
        logic es, el, ee;
        i_data_ready = s;
        i_data = d;
        i_ready = r;
        #1;
        chk("level", 32'(o_level), q.size());
        chk("valid", 32'(o_valid), 32'(q.size() != 0));
        chk("overflow", 32'(o_overflow), 32'(m_ovf));
        if (!o_valid) chk("markers_idle", {o_sof, o_eol, o_eof}, 0);
        if (stall_prev) chk("stall_hold", o_pixel, prev_pix);
        xfer = o_valid && r;
        if (xfer) begin
            if (q.size() == 0) chk("unexpected_pixel", o_pixel, 0);
            else begin
                exp = q.pop_front();
                chk("pixel", o_pixel, exp);
            end
            es = (m_col == 0) && (m_row == 0);
            el = (m_col == W - 1);
            ee = el && (m_row == H - 1);
            chk("sof", 32'(o_sof), 32'(es));
            chk("eol", 32'(o_eol), 32'(el));
            chk("eof", 32'(o_eof), 32'(ee));
            n_sof += int'(o_sof);
            n_eol += int'(o_eol);
            n_eof += int'(o_eof);
            if (el) begin
                m_col = 0;
                m_row = (m_row == H - 1) ? 0 : m_row + 1;
            end else m_col++;
        end
        stall_prev = o_valid && !r;
        prev_pix = o_pixel;
        obs_valid = o_valid;
        obs_level = o_level;
        obs_sof = o_sof;
        obs_pix = o_pixel;
        if (s) begin
            if (q.size() < DEPTH) q.push_back(conv(d));
            else m_ovf = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        i_data_ready = 1'b0;
        i_ready = 1'b0;
        #2;
        i_reset = 1'b1;
        #1;
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_level", 32'(o_level), 0);
        chk("rst_ovf", 32'(o_overflow), 0);
        chk("rst_pixel", o_pixel, 0);
        chk("rst_markers", {o_sof, o_eol, o_eof}, 0);
        @(negedge clk);
        i_reset = 1'b0;
        q.delete();
        m_col = 0;
        m_row = 0;
        m_ovf = 1'b0;
        stall_prev = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) tick(1'b0, 24'h0, 1'b1);
        tick(1'b0, 24'h0, 1'b1);
        chk("drained", 32'(obs_valid), 0);
    endtask

    initial begin
        i_reset = 1'b1;
        i_data = '0;
        i_data_ready = 1'b0;
        i_ready = 1'b0;
        @(negedge clk);
        do_reset();

        tbl[0] = '{s: 1'b1, d: 24'h102030, r: 1'b1, ev: 1'b0, el: 5'd0, es: 1'b0};
        tbl[1] = '{s: 1'b0, d: 24'h000000, r: 1'b1, ev: 1'b1, el: 5'd1, es: 1'b1};
        tbl[2] = '{s: 1'b0, d: 24'h000000, r: 1'b1, ev: 1'b0, el: 5'd0, es: 1'b0};
        for (int i = 0; i < 3; i++) begin
            tick(tbl[i].s, tbl[i].d, tbl[i].r);
            chk("tbl_valid", 32'(obs_valid), 32'(tbl[i].ev));
            chk("tbl_level", 32'(obs_level), 32'(tbl[i].el));
            chk("tbl_sof", 32'(obs_sof), 32'(tbl[i].es));
        end

        // Full with simultaneous pop: no drop, new pixel last.
        do_reset();
        for (int i = 0; i < DEPTH; i++) tick(1'b1, 24'h100000 + 24'(i), 1'b0);
        tick(1'b1, 24'hABCDEF, 1'b1);
        tick(1'b0, 24'h0, 1'b0);
        chk("full_pushpop_level", 32'(obs_level), DEPTH);
        chk("full_pushpop_ovf", 32'(o_overflow), 0);
        drain();

        // Overflow: 17th strobe dropped.
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) tick(1'b1, 24'h200000 + 24'(i), 1'b0);
        tick(1'b0, 24'h0, 1'b0);
        chk("ovf_level", 32'(obs_level), DEPTH);
        chk("ovf_set", 32'(o_overflow), 1);
        drain();
        chk("ovf_sticky", 32'(o_overflow), 1);

        // Frame markers across 9 pixels.
        do_reset();
        n_sof = 0; n_eol = 0; n_eof = 0;
        for (int i = 0; i < 9; i++) tick(1'b1, 24'h300000 + 24'(i), 1'b1);
        drain();
        chk("frame_sof_count", n_sof, 2);
        chk("frame_eol_count", n_eol, 2);
        chk("frame_eof_count", n_eof, 1);

        // Random stalls.
        do_reset();
        for (int i = 0; i < 300; i++)
            tick(1'($urandom_range(0, 1)), 24'($urandom), 1'($urandom_range(0, 2) != 0));
        drain();

        // Reset mid-frame with 5 entries buffered.
        do_reset();
        for (int i = 0; i < 3; i++) tick(1'b1, 24'h400000 + 24'(i), 1'b1);
        tick(1'b0, 24'h0, 1'b1);
        for (int i = 0; i < 5; i++) tick(1'b1, 24'h500000 + 24'(i), 1'b0);
        chk("midframe_level", 32'(o_level), 5);
        do_reset();
        tick(1'b1, 24'h010203, 1'b1);
        tick(1'b0, 24'h0, 1'b1);
        chk("post_reset_sof", 32'(obs_sof), 1);
        chk("post_reset_valid", 32'(obs_valid), 1);

`ifdef PIXEL_OUT_GRAY_EN
        tick(1'b1, 24'hFF8000, 1'b1);
        tick(1'b0, 24'h0, 1'b1);
        chk("gray_pixel", obs_pix, 24'h7F7F7F);
`endif
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
